// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory write port.
// Frame: HDR, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, XOR checksum.
module imem_loader #(
    parameter int unsigned DW     = 8,
    parameter int unsigned AW     = 16,
    parameter logic [7:0]  HDR    = 8'hA5,
    parameter int unsigned TO_CYC = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] mem_din,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          busy,
    output logic          load_done,
    output logic          load_err
);

    localparam int unsigned TW = $clog2(TO_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    addr_hi_q, addr_hi_nxt;
    logic [7:0]    len_hi_q, len_hi_nxt;
    logic [AW-1:0] ptr_q, ptr_nxt;
    logic [15:0]   rem_q, rem_nxt;
    logic [7:0]    csum_q, csum_nxt;
    logic [TW-1:0] to_cnt_q, to_cnt_nxt;
    logic          mem_we_nxt;
    logic [DW-1:0] mem_din_nxt;
    logic [AW-1:0] mem_addr_nxt;
    logic          accept;
    logic          in_frame;

    assign accept   = in_valid && in_ready;
    assign in_frame = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);

    // Frame parser, write issue and idle timeout
    always_comb begin
        state_nxt    = state;
        addr_hi_nxt  = addr_hi_q;
        len_hi_nxt   = len_hi_q;
        ptr_nxt      = ptr_q;
        rem_nxt      = rem_q;
        csum_nxt     = csum_q;
        to_cnt_nxt   = '0;
        mem_we_nxt   = 1'b0;
        mem_din_nxt  = mem_din;
        mem_addr_nxt = mem_addr;

        case (state)
            S_IDLE: begin
                if (accept && (in_data == HDR)) begin
                    state_nxt = S_ADDR_H;
                    csum_nxt  = 8'h00;
                end
            end
            S_ADDR_H: begin
                if (accept) begin
                    addr_hi_nxt = in_data;
                    csum_nxt    = csum_q ^ in_data;
                    state_nxt   = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (accept) begin
                    ptr_nxt   = AW'({addr_hi_q, in_data});
                    csum_nxt  = csum_q ^ in_data;
                    state_nxt = S_LEN_H;
                end
            end
            S_LEN_H: begin
                if (accept) begin
                    len_hi_nxt = in_data;
                    csum_nxt   = csum_q ^ in_data;
                    state_nxt  = S_LEN_L;
                end
            end
            S_LEN_L: begin
                if (accept) begin
                    csum_nxt = csum_q ^ in_data;
                    rem_nxt  = {len_hi_q, in_data};
                    state_nxt = ({len_hi_q, in_data} == 16'h0000) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    mem_we_nxt   = 1'b1;
                    mem_din_nxt  = DW'(in_data);
                    mem_addr_nxt = ptr_q;
                    ptr_nxt      = ptr_q + AW'(1);
                    rem_nxt      = rem_q - 16'd1;
                    csum_nxt     = csum_q ^ in_data;
                    if (rem_q == 16'd1) state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) state_nxt = (in_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Abort when the idle run inside a frame reaches TO_CYC
        if (in_frame && !accept) begin
            if (to_cnt_q == TW'(TO_CYC - 1)) begin
                state_nxt  = S_ERR;
                mem_we_nxt = 1'b0;
            end else begin
                to_cnt_nxt = to_cnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_hi_q <= '0;
            len_hi_q  <= '0;
            ptr_q     <= '0;
            rem_q     <= '0;
            csum_q    <= '0;
            to_cnt_q  <= '0;
            mem_we    <= 1'b0;
            mem_din   <= '0;
            mem_addr  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_hi_q <= addr_hi_nxt;
            len_hi_q  <= len_hi_nxt;
            ptr_q     <= ptr_nxt;
            rem_q     <= rem_nxt;
            csum_q    <= csum_nxt;
            to_cnt_q  <= to_cnt_nxt;
            mem_we    <= mem_we_nxt;
            mem_din   <= mem_din_nxt;
            mem_addr  <= mem_addr_nxt;
            in_ready  <= (state_nxt != S_DONE) && (state_nxt != S_ERR);
            busy      <= (state_nxt != S_IDLE);
            load_done <= (state_nxt == S_DONE);
            load_err  <= (state_nxt == S_ERR);
        end
    end

endmodule
